// File: rtl/mac_seq_ctrl_pkg.sv
// mac_seq_ctrl_pkg: shared widths and state type for the MAC job sequencer
package mac_seq_ctrl_pkg;
  localparam int PSUM_WIDTH = 24;
  localparam int LANE_WIDTH = PSUM_WIDTH / 2;
  localparam int MAC_LEN_WIDTH = 8;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} mac_state_e;
endpackage

// File: rtl/mac_seq_ctrl_if.sv
// mac_seq_ctrl_if: job descriptor, operand stream and result handshakes of the MAC sequencer
interface mac_seq_ctrl_if import mac_seq_ctrl_pkg::*; #(parameter int LEN_WIDTH = MAC_LEN_WIDTH) ();
  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [LEN_WIDTH-1:0]  cfg_len;
  logic                  cfg_mode;
  logic                  cfg_is_first;
  logic                  op_valid;
  logic                  op_ready;
  logic [7:0]            op_a;
  logic [7:0]            op_b;
  logic                  res_valid;
  logic                  res_ready;
  logic [PSUM_WIDTH-1:0] res_data;
  logic                  res_mode;
  logic                  busy;
  modport master (
    output cfg_valid, cfg_len, cfg_mode, cfg_is_first, op_valid, op_a, op_b, res_ready,
    input  cfg_ready, op_ready, res_valid, res_data, res_mode, busy
  );
  modport slave (
    input  cfg_valid, cfg_len, cfg_mode, cfg_is_first, op_valid, op_a, op_b, res_ready,
    output cfg_ready, op_ready, res_valid, res_data, res_mode, busy
  );
endinterface

// File: rtl/mac_seq_ctrl_multiplier.sv
// mac_seq_ctrl_multiplier: 8x8 or dual 4x8 product, activation signedness chosen by is_first
module mac_seq_ctrl_multiplier import mac_seq_ctrl_pkg::*; (
  input  logic [7:0]            i_a,
  input  logic [7:0]            i_b,
  input  logic                  i_mode,
  input  logic                  i_is_first,
  output logic [PSUM_WIDTH-1:0] o_prod
);
  logic signed [15:0] w_a, w_b, w_p;
  logic signed [11:0] w_ha, w_la, w_lb, w_ph, w_pl;
  assign w_a  = {{8{i_a[7] & ~i_is_first}}, i_a};
  assign w_b  = {{8{i_b[7]}}, i_b};
  assign w_ha = {{8{i_a[7] & ~i_is_first}}, i_a[7:4]};
  assign w_la = {{8{i_a[3] & ~i_is_first}}, i_a[3:0]};
  assign w_lb = {{4{i_b[7]}}, i_b};
  assign w_p  = w_a * w_b;
  assign w_ph = w_ha * w_lb;
  assign w_pl = w_la * w_lb;
  assign o_prod = i_mode ? {w_ph, w_pl} : {{(PSUM_WIDTH-16){w_p[15]}}, w_p};
endmodule

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: sequences one multiplier through a dot-product job and returns the accumulated sum
module mac_seq_ctrl import mac_seq_ctrl_pkg::*; #(parameter int LEN_WIDTH = MAC_LEN_WIDTH) (
  input logic          clk,
  input logic          rst_n,
  mac_seq_ctrl_if.slave bus
);
  mac_state_e            r_state;
  logic [LEN_WIDTH-1:0]  r_cnt;
  logic                  r_mode, r_is_first, r_s1_valid;
  logic [7:0]            r_a, r_b;
  logic [PSUM_WIDTH-1:0] r_acc, w_prod, w_acc_nxt;
  logic                  r_cfg_ready, r_op_ready, r_res_valid, r_busy;
  mac_seq_ctrl_multiplier u_mul (
    .i_a        (r_a),
    .i_b        (r_b),
    .i_mode     (r_mode),
    .i_is_first (r_is_first),
    .o_prod     (w_prod)
  );
  // lane mode keeps the halves independent so the lo lane never carries into hi
  assign w_acc_nxt = r_mode ? {r_acc[PSUM_WIDTH-1:LANE_WIDTH] + w_prod[PSUM_WIDTH-1:LANE_WIDTH],
                               r_acc[LANE_WIDTH-1:0] + w_prod[LANE_WIDTH-1:0]}
                            : r_acc + w_prod;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_mode      <= 1'b0;
      r_is_first  <= 1'b0;
      r_s1_valid  <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_cfg_ready <= 1'b1;
      r_op_ready  <= 1'b0;
      r_res_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_s1_valid <= 1'b0;
      if (r_s1_valid) r_acc <= w_acc_nxt;
      case (r_state)
        IDLE: if (bus.cfg_valid) begin
          r_mode      <= bus.cfg_mode;
          r_is_first  <= bus.cfg_is_first;
          r_acc       <= '0;
          r_cnt       <= bus.cfg_len;
          r_state     <= (bus.cfg_len == '0) ? DONE : RUN;
          r_op_ready  <= (bus.cfg_len != '0);
          r_res_valid <= (bus.cfg_len == '0);
          r_cfg_ready <= 1'b0;
          r_busy      <= 1'b1;
        end
        RUN: if (bus.op_valid) begin
          r_a        <= bus.op_a;
          r_b        <= bus.op_b;
          r_s1_valid <= 1'b1;
          r_cnt      <= r_cnt - LEN_WIDTH'(1);
          if (r_cnt == LEN_WIDTH'(1)) begin
            r_state    <= DRAIN;
            r_op_ready <= 1'b0;
          end
        end
        DRAIN: begin
          r_state     <= DONE;
          r_res_valid <= 1'b1;
        end
        DONE: if (bus.res_ready) begin
          r_state     <= IDLE;
          r_res_valid <= 1'b0;
          r_cfg_ready <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end
  assign bus.cfg_ready = r_cfg_ready;
  assign bus.op_ready  = r_op_ready;
  assign bus.res_valid = r_res_valid;
  assign bus.res_data  = r_acc;
  assign bus.res_mode  = r_mode;
  assign bus.busy      = r_busy;
endmodule
